hv_stream_narrow: RTL and testbench

Width down-converter on the result path of the HDC accelerator. It accepts wide AXI-Stream beats from the accelerator's result master port (1024-bit bundled hypervectors, TLAST on the final beat) and re-emits each one as consecutive narrow beats for the DMA write channel. Lane 0 goes first. It sits directly downstream of the top-level `M_AXIS_*` interface and runs in the `AXIS_ACLK` domain.

---
 rtl/hv_stream_pkg.sv | 17 +
 rtl/hv_stream_narrow.sv | 131 +++++++++++++
 tb/tb_hv_stream_narrow.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/hv_stream_pkg.sv
// hv_stream_pkg
//   Shared constants and types for the HDC result-path stream blocks.
//   HV_BUS_W   : accelerator hypervector bus width (shared with the accelerator top)
//   DMA_BUS_W  : DMA write-channel data width
//   HV_RATIO   : narrow beats per wide beat
//   HV_SUB_W   : width of the slice index
//   frame_cnt_t: 16-bit narrow-beat counter type
package hv_stream_pkg;

  localparam int HV_BUS_W  = 1024;
  localparam int DMA_BUS_W = 64;
  localparam int HV_RATIO  = HV_BUS_W / DMA_BUS_W;
  localparam int HV_SUB_W  = $clog2(HV_RATIO);

  typedef logic [15:0] frame_cnt_t;

endpackage

// File: rtl/hv_stream_narrow.sv
// hv_stream_narrow
//   Width down-converter: takes one IN_W-bit AXI-Stream beat and re-emits it
//   as RATIO consecutive OUT_W-bit beats, lane 0 first. TLAST is carried only
//   on the final slice of a wide beat that had TLAST set.
//
// Ports
//   AXIS_ACLK, AXIS_ARESETN   : clock, asynchronous active-low reset
//   S_AXIS_TVALID/TREADY/TDATA/TLAST : wide input stream
//   M_AXIS_TVALID/TREADY/TDATA/TSTRB/TLAST : narrow output stream
//   frame_beats : narrow beats emitted in the current / most recent frame
//   frame_done  : one-cycle pulse in the cycle after the TLAST handshake
//
// Handshake semantics (both ports): a beat transfers on a rising clock edge
// where VALID and READY are both high. A source never drops VALID, and never
// changes DATA/LAST, while VALID is high and READY is low.
module hv_stream_narrow
  import hv_stream_pkg::*;
#(
  parameter int IN_W  = HV_BUS_W,
  parameter int OUT_W = DMA_BUS_W
) (
  input  logic                 AXIS_ACLK,
  input  logic                 AXIS_ARESETN,
  input  logic                 S_AXIS_TVALID,
  output logic                 S_AXIS_TREADY,
  input  logic [IN_W-1:0]      S_AXIS_TDATA,
  input  logic                 S_AXIS_TLAST,
  output logic                 M_AXIS_TVALID,
  input  logic                 M_AXIS_TREADY,
  output logic [OUT_W-1:0]     M_AXIS_TDATA,
  output logic [OUT_W/8-1:0]   M_AXIS_TSTRB,
  output logic                 M_AXIS_TLAST,
  output logic [15:0]          frame_beats,
  output logic                 frame_done
);

  localparam int RATIO = IN_W / OUT_W;
  localparam int SUB_W = $clog2(RATIO);
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(RATIO - 1);

  if (IN_W % OUT_W != 0) begin : g_chk_div
    $error("hv_stream_narrow: IN_W must be a multiple of OUT_W");
  end
  if (OUT_W % 8 != 0) begin : g_chk_byte
    $error("hv_stream_narrow: OUT_W must be a multiple of 8");
  end
  if (RATIO < 2 || (RATIO & (RATIO - 1)) != 0) begin : g_chk_ratio
    $error("hv_stream_narrow: IN_W/OUT_W must be a power of two >= 2");
  end

  logic [IN_W-1:0]  buf_q;
  logic             buf_last_q;
  logic             full_q;
  logic [SUB_W-1:0] sub_q;
  frame_cnt_t       frame_cnt_q;
  logic             frame_done_q;
  // High from reset / after a TLAST handshake until the next narrow handshake,
  // so that handshake restarts the count at 1.
  logic             new_frame_q;

  logic             last_sub;
  logic             m_hs;
  logic             s_hs;

  // Constant-offset lane view keeps the output mux a clean RATIO:1 select.
  logic [OUT_W-1:0] lanes [RATIO];
  for (genvar gi = 0; gi < RATIO; gi++) begin : g_lane
    assign lanes[gi] = buf_q[gi*OUT_W +: OUT_W];
  end

  assign last_sub      = (sub_q == SUB_LAST);
  assign M_AXIS_TVALID = full_q;
  assign M_AXIS_TDATA  = lanes[sub_q];
  assign M_AXIS_TSTRB  = '1;
  assign M_AXIS_TLAST  = full_q & buf_last_q & last_sub;

  // Refill is allowed in the same cycle the final slice leaves, which gives
  // bubble-free back-to-back wide beats. M_AXIS_TREADY -> S_AXIS_TREADY is
  // the only combinational path through the block.
  assign S_AXIS_TREADY = ~full_q | (M_AXIS_TREADY & last_sub);

  assign m_hs = full_q & M_AXIS_TREADY;
  assign s_hs = S_AXIS_TVALID & S_AXIS_TREADY;

  assign frame_beats = frame_cnt_q;
  assign frame_done  = frame_done_q;

  // Buffer and slice index. A load takes priority over the final-slice
  // drain, so full stays set when both happen together.
  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN) begin
      buf_q      <= '0;
      buf_last_q <= 1'b0;
      full_q     <= 1'b0;
      sub_q      <= '0;
    end else if (s_hs) begin
      buf_q      <= S_AXIS_TDATA;
      buf_last_q <= S_AXIS_TLAST;
      full_q     <= 1'b1;
      sub_q      <= '0;
    end else if (m_hs) begin
      if (last_sub) begin
        sub_q  <= '0;
        full_q <= 1'b0;
      end else begin
        sub_q <= sub_q + 1'b1;
      end
    end
  end

  // Frame counter: saturating, restarts at 1 on the first beat of a frame,
  // holds its final value after the TLAST beat until the next frame starts.
  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN) begin
      frame_cnt_q  <= '0;
      frame_done_q <= 1'b0;
      new_frame_q  <= 1'b1;
    end else begin
      frame_done_q <= m_hs & M_AXIS_TLAST;
      if (m_hs) begin
        new_frame_q <= M_AXIS_TLAST;
        if (new_frame_q) begin
          frame_cnt_q <= frame_cnt_t'(1);
        end else if (frame_cnt_q != '1) begin
          frame_cnt_q <= frame_cnt_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_hv_stream_narrow.sv
// tb_hv_stream_narrow
//   Directed bench for hv_stream_narrow: table-driven single-beat frame plus
//   hand-written back-to-back, random backpressure, and mid-frame reset runs.
module tb_hv_stream_narrow;

  localparam int IN_W   = 1024;
  localparam int OUT_W  = 64;
  localparam int RATIO  = 16;
  localparam int BUDGET = 3000;

  logic                AXIS_ACLK = 1'b0;
  logic                AXIS_ARESETN;
  logic                S_AXIS_TVALID;
  logic                S_AXIS_TREADY;
  logic [IN_W-1:0]     S_AXIS_TDATA;
  logic                S_AXIS_TLAST;
  logic                M_AXIS_TVALID;
  logic                M_AXIS_TREADY;
  logic [OUT_W-1:0]    M_AXIS_TDATA;
  logic [OUT_W/8-1:0]  M_AXIS_TSTRB;
  logic                M_AXIS_TLAST;
  logic [15:0]         frame_beats;
  logic                frame_done;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- clock / reset ----------------
  always #5 AXIS_ACLK = ~AXIS_ACLK;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  hv_stream_narrow dut (
    .AXIS_ACLK     (AXIS_ACLK),
    .AXIS_ARESETN  (AXIS_ARESETN),
    .S_AXIS_TVALID (S_AXIS_TVALID),
    .S_AXIS_TREADY (S_AXIS_TREADY),
    .S_AXIS_TDATA  (S_AXIS_TDATA),
    .S_AXIS_TLAST  (S_AXIS_TLAST),
    .M_AXIS_TVALID (M_AXIS_TVALID),
    .M_AXIS_TREADY (M_AXIS_TREADY),
    .M_AXIS_TDATA  (M_AXIS_TDATA),
    .M_AXIS_TSTRB  (M_AXIS_TSTRB),
    .M_AXIS_TLAST  (M_AXIS_TLAST),
    .frame_beats   (frame_beats),
    .frame_done    (frame_done)
  );

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Beat 0 uses lane k = 0x0101..01 * k; other beats carry beat and lane ids.
  function automatic logic [63:0] lane_val(input int b, input int k);
    if (b == 0) return 64'h0101_0101_0101_0101 * 64'(k);
    return {8'hC3, 8'(b), 16'(k), 32'(b * 1000 + k)};
  endfunction

  function automatic logic [IN_W-1:0] make_beat(input int b);
    logic [IN_W-1:0] w;
    for (int k = 0; k < RATIO; k++) w[k*OUT_W +: OUT_W] = lane_val(b, k);
    return w;
  endfunction

  // ---------------- scoreboard ----------------
  // bit 64 = expected TLAST, bits 63:0 = expected slice
  logic [64:0] exp_q[$];

  // ---------------- vector table ----------------
  typedef struct {
    logic        s_valid;
    logic        s_last;
    logic        m_ready;
    logic        exp_m_valid;
    logic [63:0] exp_m_data;
    logic        exp_m_last;
    logic        exp_s_ready;
    logic [15:0] exp_fb;
    logic        exp_fd;
  } vec_t;

  vec_t vecs[19];

  initial begin
    int nb;
    int cyc;
    int pulses;
    int b;
    logic        prev_stall;
    logic [63:0] prev_data;
    logic        prev_last;
    logic [64:0] e;

    // Single-beat frame, expected per cycle (sampled before the edge).
    vecs[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 64'd0, 1'b0, 1'b1, 16'd0, 1'b0};
    for (int k = 1; k <= 16; k++)
      vecs[k] = '{1'b0, 1'b0, 1'b1, 1'b1, lane_val(0, k - 1), 1'(k == 16), 1'(k == 16),
                  16'(k - 1), 1'b0};
    vecs[17] = '{1'b0, 1'b0, 1'b1, 1'b0, 64'd0, 1'b0, 1'b1, 16'd16, 1'b1};
    vecs[18] = '{1'b0, 1'b0, 1'b1, 1'b0, 64'd0, 1'b0, 1'b1, 16'd16, 1'b0};

    // ---------------- reset state ----------------
    AXIS_ARESETN  = 1'b0;
    S_AXIS_TVALID = 1'b0;
    S_AXIS_TLAST  = 1'b0;
    S_AXIS_TDATA  = '0;
    M_AXIS_TREADY = 1'b0;
    @(negedge AXIS_ACLK);
    #1;
    check("rst_m_valid", 64'(M_AXIS_TVALID), 64'd0);
    check("rst_m_last",  64'(M_AXIS_TLAST),  64'd0);
    check("rst_s_ready", 64'(S_AXIS_TREADY), 64'd1);
    check("rst_fb",      64'(frame_beats),   64'd0);
    check("rst_fd",      64'(frame_done),    64'd0);
    check("rst_strb",    64'(M_AXIS_TSTRB),  64'hFF);
    @(negedge AXIS_ACLK);
    AXIS_ARESETN = 1'b1;

    // ---------------- single-beat frame (table) ----------------
    for (int i = 0; i < 19; i++) begin
      @(negedge AXIS_ACLK);
      S_AXIS_TVALID = vecs[i].s_valid;
      S_AXIS_TLAST  = vecs[i].s_last;
      S_AXIS_TDATA  = make_beat(0);
      M_AXIS_TREADY = vecs[i].m_ready;
      #1;
      check($sformatf("v%0d_m_valid", i), 64'(M_AXIS_TVALID), 64'(vecs[i].exp_m_valid));
      if (vecs[i].exp_m_valid)
        check($sformatf("v%0d_m_data", i), M_AXIS_TDATA, vecs[i].exp_m_data);
      check($sformatf("v%0d_m_last", i),  64'(M_AXIS_TLAST),  64'(vecs[i].exp_m_last));
      check($sformatf("v%0d_s_ready", i), 64'(S_AXIS_TREADY), 64'(vecs[i].exp_s_ready));
      check($sformatf("v%0d_fb", i),      64'(frame_beats),   64'(vecs[i].exp_fb));
      check($sformatf("v%0d_fd", i),      64'(frame_done),    64'(vecs[i].exp_fd));
    end

    // ---------------- back-to-back 3-beat frame ----------------
    // Also covers the load-on-final-slice case at cycles 16 and 32.
    b = 0;
    for (int c = 0; c <= 49; c++) begin
      @(negedge AXIS_ACLK);
      S_AXIS_TVALID = (b < 3);
      S_AXIS_TDATA  = make_beat(b + 1);
      S_AXIS_TLAST  = (b == 2);
      M_AXIS_TREADY = 1'b1;
      #1;
      if (c <= 48)
        check($sformatf("b2b%0d_s_ready", c), 64'(S_AXIS_TREADY),
              64'((c == 0) || ((c - 1) % 16 == 15)));
      check($sformatf("b2b%0d_m_valid", c), 64'(M_AXIS_TVALID), 64'(c >= 1 && c <= 48));
      if (c >= 1 && c <= 48) begin
        check($sformatf("b2b%0d_m_data", c), M_AXIS_TDATA, lane_val((c - 1) / 16 + 1, (c - 1) % 16));
        check($sformatf("b2b%0d_m_last", c), 64'(M_AXIS_TLAST), 64'(c == 48));
      end
      if (c == 49) begin
        check("b2b_fb", 64'(frame_beats), 64'd48);
        check("b2b_fd", 64'(frame_done),  64'd1);
      end
      if (S_AXIS_TVALID && S_AXIS_TREADY) b++;
    end

    // ---------------- random backpressure, two 2-beat frames ----------------
    @(negedge AXIS_ACLK);
    S_AXIS_TVALID = 1'b0;
    nb = 0; cyc = 0; pulses = 0;
    prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;
    while (cyc < BUDGET && !(nb == 4 && exp_q.size() == 0)) begin
      @(negedge AXIS_ACLK);
      cyc++;
      S_AXIS_TVALID = (nb < 4);
      S_AXIS_TDATA  = make_beat(4 + nb);
      S_AXIS_TLAST  = (nb == 1 || nb == 3);
      M_AXIS_TREADY = 1'($urandom_range(0, 1));
      #1;
      if (prev_stall) begin
        check("rnd_valid_held", 64'(M_AXIS_TVALID), 64'd1);
        check("rnd_data_held",  M_AXIS_TDATA, prev_data);
        check("rnd_last_held",  64'(M_AXIS_TLAST), 64'(prev_last));
      end
      if (frame_done) pulses++;
      if (M_AXIS_TVALID && M_AXIS_TREADY) begin
        if (exp_q.size() == 0) begin
          check("rnd_unexpected_beat", M_AXIS_TDATA, 64'd0);
          n_fail += (M_AXIS_TDATA == 64'd0) ? 1 : 0;
        end else begin
          e = exp_q.pop_front();
          check("rnd_data", M_AXIS_TDATA, e[63:0]);
          check("rnd_last", 64'(M_AXIS_TLAST), 64'(e[64]));
        end
      end
      if (S_AXIS_TVALID && S_AXIS_TREADY) begin
        for (int k = 0; k < RATIO; k++)
          exp_q.push_back({1'(S_AXIS_TLAST && k == RATIO - 1), lane_val(4 + nb, k)});
        nb++;
      end
      prev_stall = M_AXIS_TVALID & ~M_AXIS_TREADY;
      prev_data  = M_AXIS_TDATA;
      prev_last  = M_AXIS_TLAST;
    end
    @(negedge AXIS_ACLK);
    S_AXIS_TVALID = 1'b0;
    M_AXIS_TREADY = 1'b0;
    #1;
    if (frame_done) pulses++;
    check("rnd_in_budget", 64'(cyc < BUDGET), 64'd1);
    check("rnd_q_empty",   64'(exp_q.size()), 64'd0);
    check("rnd_fd_pulses", 64'(pulses), 64'd2);
    check("rnd_fb",        64'(frame_beats), 64'd32);
    check("rnd_m_valid",   64'(M_AXIS_TVALID), 64'd0);

    // ---------------- reset mid-frame ----------------
    @(negedge AXIS_ACLK);
    S_AXIS_TVALID = 1'b1;
    S_AXIS_TDATA  = make_beat(9);
    S_AXIS_TLAST  = 1'b1;
    M_AXIS_TREADY = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge AXIS_ACLK);
      S_AXIS_TVALID = 1'b0;
      M_AXIS_TREADY = 1'b1;
    end
    @(negedge AXIS_ACLK);
    M_AXIS_TREADY = 1'b0;
    #1;
    check("mid_fb_before", 64'(frame_beats), 64'd5);
    check("mid_data_before", M_AXIS_TDATA, lane_val(9, 5));
    AXIS_ARESETN = 1'b0;
    #1;
    check("mid_rst_m_valid", 64'(M_AXIS_TVALID), 64'd0);
    check("mid_rst_m_last",  64'(M_AXIS_TLAST),  64'd0);
    check("mid_rst_fb",      64'(frame_beats),   64'd0);
    check("mid_rst_fd",      64'(frame_done),    64'd0);
    @(negedge AXIS_ACLK);
    AXIS_ARESETN = 1'b1;
    #1;
    check("mid_rel_s_ready", 64'(S_AXIS_TREADY), 64'd1);
    check("mid_rel_m_valid", 64'(M_AXIS_TVALID), 64'd0);
    @(negedge AXIS_ACLK);
    S_AXIS_TVALID = 1'b1;
    S_AXIS_TDATA  = make_beat(10);
    S_AXIS_TLAST  = 1'b1;
    M_AXIS_TREADY = 1'b1;
    @(negedge AXIS_ACLK);
    S_AXIS_TVALID = 1'b0;
    #1;
    check("mid_new_m_valid", 64'(M_AXIS_TVALID), 64'd1);
    check("mid_new_lane0",   M_AXIS_TDATA, lane_val(10, 0));
    @(negedge AXIS_ACLK);
    #1;
    check("mid_new_fb",      64'(frame_beats), 64'd1);
    check("mid_new_lane1",   M_AXIS_TDATA, lane_val(10, 1));

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
